// File: rtl/heartbeat_led_sequencer.sv
// heartbeat_led_sequencer
//
// Turns the 1 s heartbeat square wave from the clock divider into a status
// blink on a board LED. Every level change of tick_in is one half-second
// step. A latched status code N shows N on/off blinks followed by a pause
// of PAUSE_STEPS off steps. Code 0 gives a plain heartbeat, toggling the LED
// on every step. A watchdog forces the LED solid on when the heartbeat stalls.
//
// Parameters
//   FREQ         system clock frequency in Hz (fallback watchdog limit)
//   TIMEOUT_CYC  clk cycles without a step before tick_lost asserts
//   CODE_W       status code width
//   PAUSE_STEPS  off steps appended after the last blink (>= 1)
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   tick_in     heartbeat square wave, same clock domain
//   code_in     requested status code
//   code_valid  one-cycle strobe capturing code_in into the pending code
//   led         LED drive (registered)
//   busy        blink pattern in progress (registered)
//   step_pulse  one-cycle pulse per detected tick edge (registered)
//   tick_lost   watchdog flag, sticky until the next tick edge (registered)

module heartbeat_led_sequencer #(
  parameter int unsigned FREQ        = 100000000,
  parameter int unsigned TIMEOUT_CYC = FREQ,
  parameter int unsigned CODE_W      = 4,
  parameter int unsigned PAUSE_STEPS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_in,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              led,
  output logic              busy,
  output logic              step_pulse,
  output logic              tick_lost
);

  // A zero timeout would make the watchdog meaningless; fall back to one
  // second of clock cycles in that case.
  localparam int unsigned WDOG_LIM  = (TIMEOUT_CYC != 0) ? TIMEOUT_CYC : FREQ;
  localparam logic [31:0] WDOG_MAX  = 32'(WDOG_LIM);
  localparam logic [31:0] WDOG_PRE  = 32'(WDOG_LIM - 1);
  localparam int unsigned PCNT_W    = (PAUSE_STEPS > 1) ? $clog2(PAUSE_STEPS) : 1;
  localparam logic [PCNT_W-1:0] PCNT_INIT = PCNT_W'(PAUSE_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              tick_d;
  logic              step;
  logic              timeout;
  logic [CODE_W-1:0] pend_code;
  logic [CODE_W-1:0] act_code;
  logic [CODE_W-1:0] cnt, cnt_nxt;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt;
  logic [31:0]       wdog;
  logic              led_nxt;
  logic              busy_nxt;

  assign step = tick_in ^ tick_d;

  // A strobe arriving on the same cycle as an IDLE step takes priority over
  // the previously latched code.
  assign act_code = code_valid ? code_in : pend_code;

  // Fires only on the single cycle the counter would reach the limit; once
  // saturated it stays quiet. A simultaneous edge always wins.
  assign timeout = !step && (wdog == WDOG_PRE);

  // Next-state logic: transitions only on steps, watchdog parks in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pcnt_nxt  = pcnt;
    if (step) begin
      case (state)
        IDLE: begin
          if (act_code != '0) begin
            state_nxt = ON;
            cnt_nxt   = act_code;
          end
        end
        ON: begin
          state_nxt = OFF;
          cnt_nxt   = cnt - 1'b1;
        end
        OFF: begin
          if (cnt != '0) begin
            state_nxt = ON;
          end else begin
            state_nxt = PAUSE;
            pcnt_nxt  = PCNT_INIT;
          end
        end
        PAUSE: begin
          if (pcnt != '0) begin
            pcnt_nxt = pcnt - 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  // Output logic: values loaded into the registered outputs.
  always_comb begin
    led_nxt = led;
    if (step) begin
      case (state)
        IDLE:    led_nxt = (act_code == '0) ? ~led : 1'b1;
        ON:      led_nxt = 1'b0;
        OFF:     led_nxt = (cnt != '0);
        PAUSE:   led_nxt = 1'b0;
        default: led_nxt = 1'b0;
      endcase
    end else if (timeout) begin
      led_nxt = 1'b1;
    end
    busy_nxt = (state_nxt != IDLE);
  end

  // Register stage: edge detect, FSM, watchdog and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_d     <= 1'b0;
      pend_code  <= '0;
      cnt        <= '0;
      pcnt       <= '0;
      wdog       <= '0;
      led        <= 1'b0;
      busy       <= 1'b0;
      step_pulse <= 1'b0;
      tick_lost  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_d     <= tick_in;
      cnt        <= cnt_nxt;
      pcnt       <= pcnt_nxt;
      led        <= led_nxt;
      busy       <= busy_nxt;
      step_pulse <= step;
      if (code_valid) begin
        pend_code <= code_in;
      end
      if (step) begin
        wdog <= '0;
      end else if (wdog != WDOG_MAX) begin
        wdog <= wdog + 32'd1;
      end
      if (step) begin
        tick_lost <= 1'b0;
      end else if (timeout) begin
        tick_lost <= 1'b1;
      end
    end
  end

endmodule

// File: doc/heartbeat_led_sequencer.md
# heartbeat_led_sequencer

Consumes the toggling 1 s heartbeat square wave from the clock-divider stage and turns it into an encoded status blink on a board LED. Each tick edge is one half-second step. A latched status code N produces N on/off blinks followed by a pause, and code 0 gives a plain heartbeat. A watchdog detects a stalled heartbeat and forces the LED solid on.

## Interface
- FREQ, 100000000: system clock frequency in Hz; sets the default watchdog limit.
- TIMEOUT_CYC, FREQ: number of clk cycles without a tick edge before `tick_lost` asserts.
- CODE_W, 4: width of the status code.
- PAUSE_STEPS, 2: off steps appended after the last blink (≥1).
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- tick_in  in  1  heartbeat square wave from the divider, same clk domain; each level change is one step.
- code_in  in  CODE_W  requested status code.
- code_valid  in  1  single-cycle strobe that captures `code_in` into the pending-code register.
- led  out  1  LED drive, registered.
- busy  out  1  high while a blink pattern is in progress (state ≠ IDLE), registered.
- step_pulse  out  1  one-cycle pulse per detected tick edge, registered.
- tick_lost  out  1  watchdog flag, registered, sticky until the next tick edge.

## Operation
- Edge detect: `tick_d` holds the previous `tick_in`. A step occurs on any cycle where `tick_in != tick_d`.
- Pending code: loaded on every cycle `code_valid` is high. Never cleared except by reset.
- Code load: when a step occurs in IDLE, the active code is `code_in` if `code_valid` is high that same cycle; otherwise it is the pending code.
- Step counter `cnt` is CODE_W bits; pause counter is wide enough for PAUSE_STEPS. All FSM transitions happen only on steps.
- IDLE:
  - Code 0: toggle `led`; stay in IDLE.
  - Code ≠ 0: set `led`=1, `cnt`=code, go to ON.
- ON: set `led`=0, `cnt`=`cnt`−1, go to OFF.
- OFF:
  - `cnt`≠0: set `led`=1, go to ON.
  - `cnt`=0: set `led`=0, pause counter = PAUSE_STEPS−1, go to PAUSE.
- PAUSE:
  - Counter ≠ 0: decrement.
  - Counter = 0: go to IDLE with `led`=0.
- Pattern period for code N is 2N+PAUSE_STEPS+1 steps.
- A `code_valid` received mid-pattern updates only the pending code. It takes effect at the next IDLE step.
- Watchdog:
  - A 32-bit counter clears on every step and otherwise increments, saturating at TIMEOUT_CYC.
  - When it reaches TIMEOUT_CYC without a step: `tick_lost`=1, `led`=1, state=IDLE, `busy`=0.
- Recovery: the first step after `tick_lost` clears `tick_lost` and performs the normal IDLE action on that step.
- Edge and timeout in the same cycle: the edge wins. The counter clears and `tick_lost` does not assert.

## Timing
- Reset values: `led`=0, `busy`=0, `step_pulse`=0, `tick_lost`=0, `tick_d`=0, pending code=0, state=IDLE, all counters=0.
- The first `tick_in` level after reset counts as a step if it is 1, because `tick_d` resets to 0.
- Latency: if `tick_in` changes and is first sampled at clk edge k, then `step_pulse`, `led` and `busy` update at edge k, visible in cycle k+1. `step_pulse` is high for exactly one cycle.
- `tick_lost` rises at the edge where the counter reaches TIMEOUT_CYC, i.e. TIMEOUT_CYC cycles after the last step edge.
- Asynchronous `rst` mid-pattern returns every register to its reset value immediately. The pattern restarts from IDLE on the first step after release.
- Minimum `tick_in` spacing is 1 cycle; consecutive-cycle toggles each produce a step.

## Test plan
- Reset/heartbeat (TIMEOUT_CYC=100, `tick_in` toggles every 11 cycles, code 0) -> `led` toggles one cycle after each `tick_in` change; `busy`=0; one `step_pulse` per toggle; `tick_lost` never asserts.
- Code 2, PAUSE_STEPS=2 -> over steps 1–7 `led` = 1,0,1,0,0,0,0; `busy` high from step 1 through step 6; pattern repeats from step 8.
- Mid-pattern code change: `code_valid` with code 1 during step 2 of a code-3 pattern -> the code-3 pattern completes (3 blinks); the next pattern shows exactly 1 blink.
- Simultaneous load: `code_valid` with code 3 on the same cycle as an IDLE step while pending=1 -> `cnt` loads 3, giving 3 blinks.
- Watchdog: stop `tick_in` for 100 cycles (TIMEOUT_CYC=100) -> `tick_lost`=1 and `led`=1 exactly 100 cycles after the last step. The next toggle clears `tick_lost` and restarts the pattern from IDLE. An edge arriving on the 100th cycle -> no `tick_lost`.
- Reset mid-pattern: assert `rst` during ON of a code-3 pattern -> all outputs 0 in the same cycle; after release the first step starts a fresh pattern using pending code 0 (heartbeat).
